// File: rtl/aes_enc_iter.sv
// Iterative AES-128/AES-256 encryptor: one round per clock, round keys expanded on the fly.
// Optional debug ports dbg_round/dbg_state appear when AES_ROUND_DBG_EN is defined.
module aes_enc_iter #(
  parameter int KEY_W = 256,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [KEY_W-1:0] in_key,
  input  logic             key_256,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
`ifdef AES_ROUND_DBG_EN
  output logic [3:0]       dbg_round,
  output logic [127:0]     dbg_state,
`endif
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Byte b of the S-box lives at bits [(255-b)*8 +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Column-major state: byte (row, col) sits at index 4*col+row; row r rotates left by r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = sbox(s[127 - 8*(4*((c + row) % 4) + row) -: 8]);
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] base, input logic [31:0] g);
    logic [31:0] w0, w1, w2, w3;
    w0 = base[127:96] ^ g;
    w1 = base[95:64]  ^ w0;
    w2 = base[63:32]  ^ w1;
    w3 = base[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_t             fsm_q, fsm_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [127:0]     st_q, st_d;
  logic [127:0]     rka_q, rka_d;
  logic [127:0]     rkb_q, rkb_d;
  logic             k256_q, k256_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [127:0]     out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_valid_q, out_valid_d;

  logic             k256_in;
  logic [127:0]     key_hi;
  logic [31:0]      last_w, rot_g, g_word;
  logic [127:0]     rk_new, rk_cur, ss, rnd_out;
  logic             last_rnd;

  assign k256_in = (KEY_W == 256) && key_256;
  assign key_hi  = in_key[KEY_W-1 -: 128];

  // AES-128: rkb holds rk[rnd-1]. AES-256: rka/rkb hold rk[rnd-2]/rk[rnd-1], except
  // in round 1 where rkb already holds rk[1] straight from the key.
  always_comb begin
    last_w   = rkb_q[31:0];
    rot_g    = sub_word({last_w[23:0], last_w[31:24]}) ^
               {rcon(k256_q ? {1'b0, rnd_q[3:1]} : rnd_q), 24'h0};
    g_word   = (!k256_q || !rnd_q[0]) ? rot_g : sub_word(last_w);
    rk_new   = next_rk(k256_q ? rka_q : rkb_q, g_word);
    rk_cur   = (k256_q && rnd_q == 4'd1) ? rkb_q : rk_new;
    last_rnd = (rnd_q == (k256_q ? 4'd14 : 4'd10));
    ss       = sub_shift(st_q);
    rnd_out  = (last_rnd ? ss : mix_cols(ss)) ^ rk_cur;
  end

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    rka_d       = rka_q;
    rkb_d       = rkb_q;
    k256_d      = k256_q;
    tag_d       = tag_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          k256_d = k256_in;
          tag_d  = in_tag;
          rka_d  = key_hi;
          rkb_d  = k256_in ? in_key[127:0] : key_hi;
          st_d   = in_data ^ key_hi;
          rnd_d  = 4'd1;
          fsm_d  = RUN;
        end
      end
      RUN: begin
        st_d  = rnd_out;
        rnd_d = rnd_q + 4'd1;
        if (!(k256_q && rnd_q == 4'd1)) begin
          rka_d = rkb_q;
          rkb_d = rk_new;
        end
        if (last_rnd) begin
          out_data_d  = rnd_out;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          rnd_d       = 4'd0;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      st_q        <= '0;
      rka_q       <= '0;
      rkb_q       <= '0;
      k256_q      <= 1'b0;
      tag_q       <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      rka_q       <= rka_d;
      rkb_q       <= rkb_d;
      k256_q      <= k256_d;
      tag_q       <= tag_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef AES_ROUND_DBG_EN
  assign dbg_round = rnd_q;
  assign dbg_state = st_q;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed-vector bench for aes_enc_iter using the FIPS-197 AES-128 and AES-256 examples.
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [255:0] in_key;
  logic         key_256;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_tag;

  int total = 0;
  int bad   = 0;

  // Low half of the 128-bit key is junk: it must be ignored in AES-128 mode.
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f,
                                    128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_enc_iter #(.KEY_W(256), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .key_256   (key_256),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [255:0] k, input logic [127:0] pt,
                           input logic m, input logic [3:0] t);
    in_key   = k;
    in_data  = pt;
    key_256  = m;
    in_tag   = t;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0; key_256 = 1'b0; in_tag = '0;
    repeat (3) tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic run_vector(input string name, input logic [255:0] k, input logic m,
                            input logic [3:0] t, input logic [127:0] ct, input int lat);
    int n;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_before: got %b want 1", name, in_ready); end
    do_accept(k, PT, m, t);
    wait_valid(n);
    total++; if (n !== lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, n, lat); end
    total++; if (out_data !== ct) begin bad++; $display("FAIL %s_data: got %h want %h", name, out_data, ct); end
    total++; if (out_tag !== t) begin bad++; $display("FAIL %s_tag: got %h want %h", name, out_tag, t); end
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s_no_bypass: got in_ready=%b want 0", name, in_ready); end
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_drop: got %b want 0", name, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_after: got %b want 1", name, in_ready); end
    $display("%s: tag=%h latency=%0d data=%h", name, t, n, ct);
  endtask

  task automatic test_aes128();
    run_vector("aes128", K128, 1'b0, 4'h3, CT128, 10);
  endtask

  task automatic test_aes256();
    run_vector("aes256", K256, 1'b1, 4'hc, CT256, 14);
  endtask

  task automatic test_backpressure();
    int n;
    do_accept(K128, PT, 1'b0, 4'h5);
    wait_valid(n);
    total++; if (n !== 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", n); end
    in_valid = 1'b1;  // offered while busy: must not be consumed
    for (int i = 0; i < 20; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d: got %b want 1", i, out_valid); end
      total++; if (out_data !== CT128) begin bad++; $display("FAIL bp_data c%0d: got %h want %h", i, out_data, CT128); end
      total++; if (out_tag !== 4'h5) begin bad++; $display("FAIL bp_tag c%0d: got %h want 5", i, out_tag); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, in_ready); end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
    repeat (3) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single_xfer: got %b want 0", out_valid); end
    $display("backpressure: held 20 cycles, tag=5");
  endtask

  task automatic test_input_stability();
    int n;
    logic [31:0] rv;
    do_accept(K128, PT, 1'b0, 4'h7);
    n = 0;
    while (!out_valid && n < 60) begin
      rv      = $urandom;
      key_256 = rv[0];
      in_key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    total++; if (n !== 10) begin bad++; $display("FAIL stab_latency: got %0d want 10", n); end
    total++; if (out_data !== CT128) begin bad++; $display("FAIL stab_data: got %h want %h", out_data, CT128); end
    total++; if (out_tag !== 4'h7) begin bad++; $display("FAIL stab_tag: got %h want 7", out_tag); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("input_stability: data=%h", out_data);
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [2];
    logic [3:0]   tg [2];
    int acc, got, extra;
    logic will_acc, will_out;
    acc = 0; got = 0; extra = 0;
    d[0] = '0; d[1] = '0; tg[0] = '0; tg[1] = '0;
    in_key = K256; in_data = PT; key_256 = 1'b1; in_tag = 4'ha;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 2; cyc++) begin
      will_acc = in_valid && in_ready;
      will_out = out_valid && out_ready;
      if (will_out) begin d[got] = out_data; tg[got] = out_tag; end
      tick();
      if (will_out) got++;
      if (will_acc) begin
        acc++;
        if (acc == 1) begin
          in_key = K128; key_256 = 1'b0; in_tag = 4'h6;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) extra++;
      tick();
    end
    out_ready = 1'b0;
    total++; if (acc !== 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
    total++; if (got !== 2) begin bad++; $display("FAIL b2b_outputs: got %0d want 2", got); end
    total++; if (extra !== 0) begin bad++; $display("FAIL b2b_duplicate: got %0d extra want 0", extra); end
    total++; if (d[0] !== CT256) begin bad++; $display("FAIL b2b_data0: got %h want %h", d[0], CT256); end
    total++; if (tg[0] !== 4'ha) begin bad++; $display("FAIL b2b_tag0: got %h want a", tg[0]); end
    total++; if (d[1] !== CT128) begin bad++; $display("FAIL b2b_data1: got %h want %h", d[1], CT128); end
    total++; if (tg[1] !== 4'h6) begin bad++; $display("FAIL b2b_tag1: got %h want 6", tg[1]); end
    $display("back_to_back: blk0 tag=%h data=%h blk1 tag=%h data=%h", tg[0], d[0], tg[1], d[1]);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    do_accept(K256, PT, 1'b1, 4'h9);
    repeat (4) tick();  // engine now in round 5
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_aborted: got %0d valid cycles want 0", seen); end
    $display("reset_mid: aborted block, valid cycles after=%0d", seen);
    run_vector("post_reset_aes128", K128, 1'b0, 4'h2, CT128, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aes128();
    test_aes256();
    test_backpressure();
    test_input_stability();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
